cmp_sort_seq: RTL and testbench

- Sequential sorter that owns one WIDTH-bit magnitude compare-and-swap datapath and schedules it over a DEPTH-entry register buffer.
- Accepts DEPTH unsigned values over a valid/ready input stream, bubble-sorts them in place at one compare per cycle, then streams them out in ascending order.
- Sits between a sample producer and downstream consumers that need ordered data, such as median or min/max selection.

---
 rtl/cmp_sort_pkg.sv | 18 +
 rtl/cmp_swap_cell.sv | 17 +
 rtl/cmp_sort_seq.sv | 164 ++++++++++++++++
 tb/tb_cmp_sort_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sort_pkg.sv
// Shared types and sizing helpers for the cmp_sort_seq sequential sorter.
package cmp_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int idxWidth(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int swapCountWidth(input int depth);
    return $clog2(depth * depth) + 1;
  endfunction

endpackage

// File: rtl/cmp_swap_cell.sv
// Combinational compare-and-swap: orders one pair, flags when the pair was out of order.
module cmp_swap_cell #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);

  // Strict compare keeps equal elements in place, which makes the sort stable.
  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/cmp_sort_seq.sv
// Load / bubble-sort / drain sequencer around a single compare-and-swap cell.
// Optional swap counter output enabled by defining CMP_SORT_SWAP_COUNT_EN.
module cmp_sort_seq
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
`ifdef CMP_SORT_SWAP_COUNT_EN
  ,
  output logic [$clog2(DEPTH*DEPTH):0] swap_count
`endif
);

  localparam int IW = idxWidth(DEPTH);
  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LastCmp = IW'(DEPTH - 2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [IW-1:0]    wrIdx_q, wrIdx_d;
  logic [IW-1:0]    cmpIdx_q, cmpIdx_d;
  logic [IW-1:0]    rdIdx_q, rdIdx_d;
  logic [IW-1:0]    passCnt_q, passCnt_d;
  logic             swapped_q, swapped_d;

  logic [IW-1:0]    cmpNext;
  logic [WIDTH-1:0] cellLo, cellHi;
  logic             cellSwap;

  assign cmpNext = cmpIdx_q + 1'b1;

  cmp_swap_cell #(.WIDTH(WIDTH)) u_cell (
    .a    (data_q[cmpIdx_q]),
    .b    (data_q[cmpNext]),
    .lo   (cellLo),
    .hi   (cellHi),
    .swap (cellSwap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      data_q    <= '{default: '0};
      wrIdx_q   <= '0;
      cmpIdx_q  <= '0;
      rdIdx_q   <= '0;
      passCnt_q <= '0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      wrIdx_q   <= wrIdx_d;
      cmpIdx_q  <= cmpIdx_d;
      rdIdx_q   <= rdIdx_d;
      passCnt_q <= passCnt_d;
      swapped_q <= swapped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    wrIdx_d   = wrIdx_q;
    cmpIdx_d  = cmpIdx_q;
    rdIdx_d   = rdIdx_q;
    passCnt_d = passCnt_q;
    swapped_d = swapped_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          data_d[wrIdx_q] = in_data;
          if (wrIdx_q == LastIdx) begin
            wrIdx_d = '0;
            state_d = SORT;
          end else begin
            wrIdx_d = wrIdx_q + 1'b1;
          end
        end
      end
      SORT: begin
        if (cellSwap) begin
          data_d[cmpIdx_q] = cellLo;
          data_d[cmpNext]  = cellHi;
        end
        // A pass ends on the last pair; a clean pass or the final pass means the buffer is ordered.
        if (cmpIdx_q == LastCmp) begin
          cmpIdx_d  = '0;
          swapped_d = 1'b0;
          if (!(swapped_q || cellSwap) || (passCnt_q == LastCmp)) begin
            state_d = DRAIN;
          end else begin
            passCnt_d = passCnt_q + 1'b1;
          end
        end else begin
          cmpIdx_d  = cmpNext;
          swapped_d = swapped_q | cellSwap;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rdIdx_q == LastIdx) begin
            rdIdx_d   = '0;
            passCnt_d = '0;
            state_d   = LOAD;
          end else begin
            rdIdx_d = rdIdx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    busy      = (state_q == SORT);
    out_valid = (state_q == DRAIN);
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == DRAIN) begin
      out_data = data_q[rdIdx_q];
      out_last = (rdIdx_q == LastIdx);
    end
  end

`ifdef CMP_SORT_SWAP_COUNT_EN
  localparam int SCW = swapCountWidth(DEPTH);

  logic [SCW-1:0] swapCnt_q, swapCnt_d;

  // The count survives DRAIN and the next LOAD so it can be read after the batch is gone.
  always_comb begin
    swapCnt_d = swapCnt_q;
    if (state_q == LOAD && state_d == SORT) begin
      swapCnt_d = '0;
    end else if (state_q == SORT && cellSwap) begin
      swapCnt_d = swapCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swapCnt_q <= '0;
    end else begin
      swapCnt_q <= swapCnt_d;
    end
  end

  assign swap_count = swapCnt_q;
`endif

endmodule

// File: tb/tb_cmp_sort_seq.sv
// Self-checking bench for cmp_sort_seq: vector table plus a reset-mid-sort sequence.
// Swap counter checks compile in when CMP_SORT_SWAP_COUNT_EN is defined.
module tb_cmp_sort_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
`ifdef CMP_SORT_SWAP_COUNT_EN
  logic [6:0] swapCount;
`endif

  cmp_sort_seq #(.WIDTH(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef CMP_SORT_SWAP_COUNT_EN
    ,
    .swap_count(swapCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element i of a batch lives in bits [4*i +: 4].
  typedef struct {
    logic [31:0] inData;
    logic [31:0] expData;
    int          expBusy;
    int          expSwaps;
    logic [3:0]  readyPat;
  } vec_t;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } sb_t;

  vec_t vecs[5];
  sb_t  sbq[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs();
    check("rstInReady", in_ready, 1);
    check("rstOutValid", out_valid, 0);
    check("rstOutData", out_data, 0);
    check("rstOutLast", out_last, 0);
    check("rstBusy", busy, 0);
`ifdef CMP_SORT_SWAP_COUNT_EN
    check("rstSwapCount", swapCount, 0);
`endif
  endtask

  // Feeds one batch; the expected sorted stream goes to the scoreboard as it is driven.
  task automatic applyStimulus(input int vi, input bit pushSb);
    if (pushSb) begin
      for (int i = 0; i < 8; i++) begin
        sbq.push_back({vecs[vi].expData[i*4 +: 4], (i == 7)});
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[vi].inData[i*4 +: 4];
      check("inReadyLoad", in_ready, 1);
    end
  endtask

  task automatic waitSort(input int expBusy, input int expSwaps);
    int  cnt = 0;
    bit  done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 4'($urandom);
      out_ready = 1'b1;
      if (busy) begin
        cnt++;
        check("inReadySort", in_ready, 0);
      end else begin
        done = 1;
      end
    end
    out_ready = 1'b0;
    check("sortFinished", done, 1);
    check("outValidAfterSort", out_valid, 1);
    if (expBusy >= 0) check("busyCycles", cnt, expBusy);
`ifdef CMP_SORT_SWAP_COUNT_EN
    check("swapCountSort", swapCount, expSwaps);
`else
    if (expSwaps < 0) check("swapArg", expSwaps, 0);
`endif
  endtask

  task automatic checkOutput(input logic [3:0] pat, input int expSwaps);
    int         got = 0;
    int         cyc = 0;
    logic [3:0] held = '0;
    bit         stalled = 0;
    sb_t        exp;
    in_valid = 1'b1;
    in_data  = 4'hA;
    while (got < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      cyc++;
      check("inReadyDrain", in_ready, 0);
      check("outValidDrain", out_valid, 1);
      if (stalled) check("outDataHold", out_data, held);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("sbUnderflow", 1, 0);
        end else begin
          exp = sbq.pop_front();
          check("outData", out_data, exp.data);
          check("outLast", out_last, exp.last);
        end
        got++;
        stalled = 0;
      end else begin
        held    = out_data;
        stalled = 1;
      end
    end
    check("drainCount", got, 8);
`ifdef CMP_SORT_SWAP_COUNT_EN
    check("swapCountHold", swapCount, expSwaps);
`else
    if (expSwaps < 0) check("swapArg", expSwaps, 0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = '{32'h76543210, 32'h76543210, 7,  0,  4'b1111};
    vecs[1] = '{32'h01234567, 32'h76543210, 49, 28, 4'b1111};
    vecs[2] = '{32'h193F0535, 32'hF9553310, -1, 14, 4'b1001};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 7,  0,  4'b1111};
    vecs[4] = '{32'h12121212, 32'h22221111, -1, 10, 4'b0110};

    #1;
    checkResetOutputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Batches run back to back; in_valid stays high through DRAIN.
    for (int vi = 0; vi < 4; vi++) begin
      applyStimulus(vi, 1);
      waitSort(vecs[vi].expBusy, vecs[vi].expSwaps);
      checkOutput(vecs[vi].readyPat, vecs[vi].expSwaps);
    end

    // Reset lands on the 10th SORT cycle of a reverse batch.
    @(negedge clk);
    in_valid = 1'b0;
    applyStimulus(1, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      check("busyBeforeReset", busy, 1);
    end
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4, 1);
    waitSort(-1, vecs[4].expSwaps);
    checkOutput(vecs[4].readyPat, vecs[4].expSwaps);

    @(negedge clk);
    in_valid = 1'b0;
    check("inReadyAfterDrain", in_ready, 1);
    check("sbEmpty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
